// File: rtl/lightpix_miso_rx_pkg.sv
// ---------------------------------------------------------------------------
// lightpix_rx_pkg
// Shared types and helpers for the LightPix miso-lane UART receiver.
//   rx_state_t    : receiver FSM states
//   PKT_WIDTH     : packet payload width (start/stop bits excluded)
//   odd_parity_ok : 1 when the XOR over all 64 packet bits is 1
// The parity check is only applied by the receiver when the macro
// LIGHTPIX_RX_PARITY_CHECK_EN is defined.
// ---------------------------------------------------------------------------
package lightpix_rx_pkg;

  localparam int PKT_WIDTH = 64;

  typedef enum logic [2:0] {
    WAIT_IDLE = 3'd0,
    IDLE      = 3'd1,
    START     = 3'd2,
    DATA      = 3'd3,
    STOP      = 3'd4,
    BREAK     = 3'd5
  } rx_state_t;

  // Bit 63 carries the parity; a good packet has an odd number of ones.
  function automatic logic odd_parity_ok(input logic [63:0] pkt);
    return ^pkt;
  endfunction

endpackage

// File: rtl/lightpix_miso_rx_if.sv
// ---------------------------------------------------------------------------
// lightpix_miso_rx_if
// Packet stream from the miso receiver to the MCP packet logic.
//   rx_data  : head-of-FIFO packet, bit 0 is the first data bit received
//   rx_valid : a packet is available
//   rx_ready : consumer can take the packet
// Handshake: a packet transfers on every rising clk edge where
// rx_valid & rx_ready is high. rx_valid and rx_data do not depend on
// rx_ready within the cycle, and once rx_valid is high the source holds
// rx_data steady until the transfer happens.
// Modports: master = receiver side, slave = consumer side.
// ---------------------------------------------------------------------------
interface lightpix_miso_rx_if #(
  parameter int WIDTH = 64
);
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/lightpix_miso_rx_fifo.sv
// ---------------------------------------------------------------------------
// lightpix_rx_fifo
// Packet FIFO between the deserializer and the consumer.
//   clk, reset : clock, asynchronous active-high reset
//   push_i     : write wdata_i (accepted when not full, or full with pop)
//   wdata_i    : packet to store
//   pop_i      : remove the head entry (ignored when empty)
//   rdata_o    : head entry, read straight out of the storage registers
//   full_o     : all FIFO_DEPTH entries occupied
//   empty_o    : no entries
// Pointers are FIFO_BITS+1 wide so full and empty are distinguishable by
// the extra MSB.
// ---------------------------------------------------------------------------
module lightpix_rx_fifo #(
  parameter int WIDTH      = 64,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_BITS  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [FIFO_BITS:0] wr_q;
  logic [FIFO_BITS:0] rd_q;
  logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic               do_push;
  logic               do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[FIFO_BITS] != rd_q[FIFO_BITS]) &&
                   (wr_q[FIFO_BITS-1:0] == rd_q[FIFO_BITS-1:0]);

  // A push into a full FIFO is fine when the head leaves on the same edge:
  // the write lands in the slot being vacated.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  assign rdata_o = mem_q[rd_q[FIFO_BITS-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q[FIFO_BITS-1:0]] <= wdata_i;
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/lightpix_miso_rx.sv
// ---------------------------------------------------------------------------
// lightpix_miso_rx
// UART deserializer for one LightPix miso lane. Synchronizes the line,
// recovers start/64-bit/stop frames at OVERSAMPLE clocks per bit and queues
// checked packets in a small FIFO.
//   clk, reset   : receive clock, asynchronous active-high reset
//   miso         : asynchronous serial line, idles high
//   rx           : packet stream (master side of lightpix_miso_rx_if)
//   frame_err    : one-cycle pulse, stop bit sampled low
//   parity_err   : one-cycle pulse, packet failed odd parity
//   overflow     : sticky, good packet dropped on a full FIFO
//   overflow_clr : synchronous clear of overflow (a new overflow wins)
//   rx_state_o   : current FSM state, for observation
// Optional feature macro: LIGHTPIX_RX_PARITY_CHECK_EN. When defined,
// packets with even parity are dropped and flagged on parity_err; when
// undefined, every packet with a good stop bit is queued and parity_err
// stays 0.
// ---------------------------------------------------------------------------
module lightpix_miso_rx
  import lightpix_rx_pkg::*;
#(
  parameter int WIDTH      = PKT_WIDTH,
  parameter int OVERSAMPLE = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_BITS  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               miso,
  lightpix_miso_rx_if.master rx,
  output logic               frame_err,
  output logic               parity_err,
  output logic               overflow,
  input  logic               overflow_clr,
  output rx_state_t          rx_state_o
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(WIDTH);
  localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  logic [1:0]       sync_q;
  logic             s;
  rx_state_t        state_q;
  logic [CW-1:0]    cnt_q;
  logic [BW-1:0]    bits_q;
  logic [WIDTH-1:0] shift_q;
  logic             frame_err_q;
  logic             parity_err_q;
  logic             overflow_q;
  logic             parity_fail;
  logic             stop_sample;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;

  // Two-flop synchronizer; resets to the idle level so reset never looks
  // like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], miso};
  end
  assign s = sync_q[1];

`ifdef LIGHTPIX_RX_PARITY_CHECK_EN
  assign parity_fail = ~odd_parity_ok(shift_q);
`else
  assign parity_fail = 1'b0;
`endif

  // The stop sample cycle: shift_q holds the complete packet here, and the
  // push is taken on the edge that closes this cycle.
  assign stop_sample = (state_q == STOP) && (cnt_q == '0);
  assign push        = stop_sample & s & ~parity_fail;
  assign pop         = rx.rx_valid & rx.rx_ready;

  // Receiver FSM. cnt_q counts down to the next sample point; in WAIT_IDLE
  // it counts consecutive high cycles instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_IDLE;
      cnt_q        <= '0;
      bits_q       <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      case (state_q)
        WAIT_IDLE: begin
          if (!s) begin
            cnt_q <= '0;
          end else if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        IDLE: begin
          if (!s) begin
            state_q <= START;
            cnt_q   <= HALF_M1;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            if (!s) begin
              state_q <= DATA;
              cnt_q   <= FULL_M1;
              bits_q  <= '0;
            end else begin
              // Line went back high mid start bit: treat as a glitch.
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            shift_q <= {s, shift_q[WIDTH-1:1]};
            cnt_q   <= FULL_M1;
            if (bits_q == LAST_BIT) state_q <= STOP;
            else                    bits_q  <= bits_q + 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            if (s) begin
              state_q      <= IDLE;
              parity_err_q <= parity_fail;
            end else begin
              state_q     <= BREAK;
              frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        BREAK: begin
          if (s) state_q <= IDLE;
        end
        default: state_q <= WAIT_IDLE;
      endcase
    end
  end

  // Overflow: a good packet arriving at a full FIFO with no pop that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                           overflow_q <= 1'b0;
    else if (push & fifo_full & ~pop)    overflow_q <= 1'b1;
    else if (overflow_clr)               overflow_q <= 1'b0;
  end

  lightpix_rx_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_BITS  (FIFO_BITS)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (shift_q),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rx.rx_valid = ~fifo_empty;
  assign rx.rx_data  = fifo_rdata;
  assign frame_err   = frame_err_q;
  assign parity_err  = parity_err_q;
  assign overflow    = overflow_q;
  assign rx_state_o  = state_q;

endmodule

// File: tb/tb_lightpix_miso_rx.sv
// ---------------------------------------------------------------------------
// tb_lightpix_miso_rx
// Self-checking bench for lightpix_miso_rx. Frames are driven bit by bit on
// miso; a packet-level model decides for each frame whether it should come
// out of the FIFO, raise frame_err / parity_err, or be dropped as overflow.
// Expected packets go into exp_q; a monitor pops and compares on every
// rx_valid & rx_ready transfer. Builds with or without
// LIGHTPIX_RX_PARITY_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_lightpix_miso_rx;
  import lightpix_rx_pkg::*;

  localparam int OS = 4;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic miso;
  logic overflow_clr;
  logic frame_err, parity_err, overflow;
  rx_state_t rx_state;

  always #5 clk = ~clk;

  lightpix_miso_rx_if #(.WIDTH(64)) rxif ();

  lightpix_miso_rx #(
    .WIDTH(64), .OVERSAMPLE(OS), .FIFO_DEPTH(4), .FIFO_BITS(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .miso         (miso),
    .rx           (rxif),
    .frame_err    (frame_err),
    .parity_err   (parity_err),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .rx_state_o   (rx_state)
  );

  // scoreboard state
  logic [63:0] exp_q[$];
  int n_vec = 0;
  int n_fail = 0;
  int exp_frame = 0, exp_parity = 0;
  int frame_seen = 0, parity_seen = 0;
  logic exp_ovf = 1'b0;
  logic rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // packet-level reference model
  function automatic logic parity_good(input logic [63:0] d);
`ifdef LIGHTPIX_RX_PARITY_CHECK_EN
    return ($countones(d) % 2) == 1;
`else
    return 1'b1;
`endif
  endfunction

  task automatic issue(input logic [63:0] d, input logic stop_ok, input logic drop);
    if (!stop_ok)            exp_frame++;
    else if (!parity_good(d)) exp_parity++;
    else if (drop)           exp_ovf = 1'b1;
    else                     exp_q.push_back(d);
  endtask

  function automatic logic [63:0] good_pkt();
    logic [63:0] d;
    d = {$urandom, $urandom};
    d[63] = ~(^d[62:0]);
    return d;
  endfunction

  // driver tasks (called at a falling edge)
  task automatic send_frame(input logic [63:0] d, input logic stop_bit, input int nbits);
    miso = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      miso = d[i];
      repeat (OS) @(negedge clk);
    end
    if (nbits == 64) begin
      miso = stop_bit;
      repeat (OS) @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    miso = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int budget);
    int k;
    rand_ready = 1'b1;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rxif.rx_valid) break;
    end
    rand_ready = 1'b0;
    rxif.rx_ready = 1'b0;
    check("drain_exp_left", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(rxif.rx_valid), 64'd0);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_frame_cnt"}, 64'(frame_seen), 64'(exp_frame));
    check({tag, "_parity_cnt"}, 64'(parity_seen), 64'(exp_parity));
    check({tag, "_overflow"}, 64'(overflow), 64'(exp_ovf));
  endtask

  // random consumer backpressure
  always @(negedge clk) if (rand_ready) rxif.rx_ready = 1'($urandom_range(0, 1));

  // monitor: pulse counting and transfer checking
  always begin
    logic [63:0] e;
    @(negedge clk);
    #2;
    if (!reset) begin
      if (frame_err) frame_seen++;
      if (parity_err) parity_seen++;
      if (rxif.rx_valid && rxif.rx_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_pkt: got %h, expected none", rxif.rx_data);
        end else begin
          e = exp_q.pop_front();
          if (rxif.rx_data !== e) begin
            n_fail++;
            $display("FAIL pkt_data: got %h expected %h", rxif.rx_data, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d expected packets pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    logic exp_good;
    reset = 1'b1;
    miso = 1'b1;
    overflow_clr = 1'b0;
    rxif.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", 64'(rxif.rx_valid), 64'd0);
    check("rst_data", rxif.rx_data, 64'd0);
    check("rst_frame", 64'(frame_err), 64'd0);
    check("rst_parity", 64'(parity_err), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_state", 64'(rx_state), 64'(WAIT_IDLE));
    reset = 1'b0;
    idle(8);
    check("idle_state", 64'(rx_state), 64'(IDLE));

    // single packet with latency
    p = 64'h8000_0000_0000_0001;
    exp_good = parity_good(p);
    issue(p, 1'b1, 1'b0);
    rxif.rx_ready = 1'b1;
    fork
      send_frame(p, 1'b1, 64);
      begin
        repeat (264) @(posedge clk);
        @(negedge clk);
        check("lat_valid_early", 64'(rxif.rx_valid), 64'd0);
        @(negedge clk);
        check("lat_valid_t263", 64'(rxif.rx_valid), 64'(exp_good));
        check("lat_frame", 64'(frame_err), 64'd0);
        check("lat_parity", 64'(parity_err), 64'(!exp_good));
        @(negedge clk);
        check("lat_valid_1cyc", 64'(rxif.rx_valid), 64'd0);
      end
    join
    idle(4);
    check_flags("single");

    // framing error, then recovery
    issue(good_pkt(), 1'b0, 1'b0);
    send_frame(good_pkt(), 1'b0, 64);
    idle(6);
    check("ferr_state", 64'(rx_state), 64'(IDLE));
    p = good_pkt();
    issue(p, 1'b1, 1'b0);
    send_frame(p, 1'b1, 64);
    idle(4);
    check_flags("frame");
    drain(50);

    // even-parity packet
    issue(64'd0, 1'b1, 1'b0);
    send_frame(64'd0, 1'b1, 64);
    idle(4);
    check_flags("parity");
    drain(50);

    // overflow: five back-to-back with no consumer
    rxif.rx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      p = good_pkt();
      issue(p, 1'b1, i == 4);
      send_frame(p, 1'b1, 64);
    end
    idle(4);
    check("ovf_valid", 64'(rxif.rx_valid), 64'd1);
    check_flags("ovf_set");
    overflow_clr = 1'b1;
    @(negedge clk);
    overflow_clr = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    check_flags("ovf_clr");
    drain(100);

    // full FIFO with a pop on the push edge
    for (int i = 0; i < 4; i++) begin
      p = good_pkt();
      issue(p, 1'b1, 1'b0);
      send_frame(p, 1'b1, 64);
    end
    p = good_pkt();
    issue(p, 1'b1, 1'b0);
    fork
      send_frame(p, 1'b1, 64);
      begin
        repeat (264) @(negedge clk);
        rxif.rx_ready = 1'b1;
        @(negedge clk);
        rxif.rx_ready = 1'b0;
      end
    join
    idle(4);
    check_flags("fullpop");
    drain(100);

    // reset in the middle of a packet
    p = good_pkt();
    issue(p, 1'b1, 1'b0);
    send_frame(p, 1'b1, 64);
    idle(4);
    check("mid_valid_before", 64'(rxif.rx_valid), 64'd1);
    send_frame(good_pkt(), 1'b1, 32);
    reset = 1'b1;
    miso = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    check("mid_valid", 64'(rxif.rx_valid), 64'd0);
    check("mid_data", rxif.rx_data, 64'd0);
    check("mid_frame", 64'(frame_err), 64'd0);
    check("mid_parity", 64'(parity_err), 64'd0);
    check("mid_state", 64'(rx_state), 64'(WAIT_IDLE));
    @(negedge clk);
    reset = 1'b0;
    idle(6);
    p = good_pkt();
    issue(p, 1'b1, 1'b0);
    send_frame(p, 1'b1, 64);
    idle(4);
    check_flags("mid");
    drain(50);

    // randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      logic bad;
      int gap;
      p = {$urandom, $urandom};
      bad = ($urandom_range(0, 5) == 0);
      gap = $urandom_range(0, 5);
      issue(p, !bad, 1'b0);
      send_frame(p, !bad, 64);
      idle(bad ? gap + 3 : gap);
    end
    idle(4);
    drain(200);
    check_flags("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
